// File: rtl/kmkz_pkg.sv
// Shared definitions for the kamikaze instruction-fetch bus master.
package kmkz_pkg;

    localparam int KMKZ_XLEN       = 32;
    localparam int KMKZ_WORD_BYTES = 4;

    // One returned instruction word together with its fetch address and bus error.
    typedef struct packed {
        logic [KMKZ_XLEN-1:0] data;
        logic [KMKZ_XLEN-1:0] addr;
        logic                 err;
    } kmkz_rentry_t;

    localparam int KMKZ_RENTRY_W = $bits(kmkz_rentry_t);

    // Clear the byte-offset bits so an address points at a whole word.
    function automatic logic [KMKZ_XLEN-1:0] kmkz_word_align(input logic [KMKZ_XLEN-1:0] a);
        return {a[KMKZ_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/kmkz_ifetch_rbuf.sv
// Response buffer: small synchronous FIFO of {data, addr, err} entries with a
// clear that wins over push and pop. A push into a full buffer is accepted only
// when a pop happens in the same cycle.
module kmkz_ifetch_rbuf
    import kmkz_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [KMKZ_RENTRY_W-1:0] i_entry,
    input  logic                     i_pop,
    output logic [KMKZ_RENTRY_W-1:0] o_head,
    output logic [CW-1:0]            o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [KMKZ_RENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     w_pop;
    logic                     w_push;

    assign w_pop   = i_pop & (r_count != '0);
    assign w_push  = i_push & ((r_count != CW'(DEPTH)) | w_pop);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

    // Entry storage; reset to zero so the head reads as all-zero out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/kmkz_ifetch_bus.sv
// Instruction-side bus master: issues pipelined word reads under a credit limit,
// buffers in-order responses for the fetch FIFO, and on a branch drops every
// response that belongs to the old stream.
module kmkz_ifetch_bus
    import kmkz_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        accept_i,
    output logic [31:0] data_o,
    output logic [31:0] data_addr_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    localparam int          CW           = $clog2(BUF_DEPTH + 1);
    localparam int          SW           = CW + 2;
    localparam logic [31:0] RESET_WADDR  = {RESET_ADDR[31:2], 2'b00};

    logic [31:0]              r_fetch_addr;
    logic [31:0]              r_resp_addr;
    logic [31:0]              r_hold_addr;
    logic [CW-1:0]            r_outstanding;
    logic [CW-1:0]            r_drop_cnt;
    logic                     r_hold;
    logic                     r_hold_stale;
    logic                     r_run;

    logic                     w_ready;
    logic                     w_pop;
    logic                     w_gnt;
    logic                     w_gnt_stale;
    logic                     w_rsp_drop;
    logic                     w_rsp_keep;
    logic                     w_push;
    logic [SW-1:0]            w_used;
    logic [CW-1:0]            w_buf_count;
    logic                     w_empty;
    logic                     w_full;
    logic [KMKZ_RENTRY_W-1:0] w_head_raw;
    kmkz_rentry_t             w_head;
    kmkz_rentry_t             w_push_entry;

    // A word popped this cycle frees its slot for a request raised in the same cycle,
    // which is what sustains one word per cycle at the minimum depth.
    assign w_ready     = ~w_empty;
    assign w_pop       = accept_i & w_ready;
    assign w_used      = SW'(r_outstanding) + SW'(w_buf_count) + SW'(r_drop_cnt) - SW'(w_pop);
    assign bus_req_o   = r_hold | (r_run & (w_used < SW'(BUF_DEPTH)));
    assign bus_addr_o  = r_hold ? r_hold_addr : r_fetch_addr;
    assign w_gnt       = bus_req_o & bus_gnt_i;
    // Any request granted in a flush cycle, or held across an earlier flush, is old-stream.
    assign w_gnt_stale = r_hold ? (r_hold_stale | flush_i) : flush_i;

    assign w_rsp_drop  = bus_rvalid_i & (r_drop_cnt != '0);
    assign w_rsp_keep  = bus_rvalid_i & (r_drop_cnt == '0);
    assign w_push      = w_rsp_keep & ~flush_i & (~w_full | w_pop);

    assign w_push_entry = '{data: bus_rdata_i, addr: r_resp_addr, err: bus_err_i};
    assign w_head       = kmkz_rentry_t'(w_head_raw);
    assign data_o       = w_head.data;
    assign data_addr_o  = w_head.addr;
    assign err_o        = w_head.err;
    assign ready_o      = w_ready;

    kmkz_ifetch_rbuf #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_rbuf (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_clear (flush_i),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head_raw),
        .o_count (w_buf_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Keep requests low during reset; the first request follows the first edge after release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_run <= 1'b0;
        else       r_run <= 1'b1;
    end

    // Credit counters: live requests in flight and old-stream responses still to discard.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (flush_i) begin
            r_outstanding <= '0;
            r_drop_cnt    <= CW'(SW'(r_drop_cnt) - SW'(w_rsp_drop) + SW'(r_outstanding)
                                 - SW'(w_rsp_keep) + SW'(w_gnt));
        end else begin
            r_outstanding <= r_outstanding + CW'(w_gnt & ~w_gnt_stale) - CW'(w_rsp_keep);
            r_drop_cnt    <= r_drop_cnt + CW'(w_gnt & w_gnt_stale) - CW'(w_rsp_drop);
        end
    end

    // Next request address and the address tag for the next kept response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_addr <= RESET_WADDR;
            r_resp_addr  <= RESET_WADDR;
        end else if (flush_i) begin
            r_fetch_addr <= kmkz_word_align(flush_addr_i);
            r_resp_addr  <= kmkz_word_align(flush_addr_i);
        end else begin
            if (w_gnt && !w_gnt_stale) r_fetch_addr <= r_fetch_addr + 32'(KMKZ_WORD_BYTES);
            if (w_push)                r_resp_addr  <= r_resp_addr + 32'(KMKZ_WORD_BYTES);
        end
    end

    // Freeze a raised but ungranted request, remembering whether it predates a flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold       <= 1'b0;
            r_hold_stale <= 1'b0;
            r_hold_addr  <= RESET_WADDR;
        end else begin
            r_hold       <= bus_req_o & ~bus_gnt_i;
            r_hold_stale <= bus_req_o & ~bus_gnt_i & w_gnt_stale;
            if (bus_req_o && !bus_gnt_i) r_hold_addr <= bus_addr_o;
        end
    end

endmodule

// File: tb/tb_kmkz_ifetch_bus.sv
// Bench for kmkz_ifetch_bus: a behavioural bus slave plus a transaction-level
// model (queues of tagged requests and delivered words) checked every cycle.
module tb_kmkz_ifetch_bus;

    localparam logic [31:0] RST_ADDR = 32'hFFFF_FFFC;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        accept_i;
    logic [31:0] data_o;
    logic [31:0] data_addr_o;
    logic        ready_o;
    logic        err_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    // clock / reset block
    always #5 clk = ~clk;

    kmkz_ifetch_bus #(
        .RESET_ADDR (RST_ADDR),
        .BUF_DEPTH  (DEPTH)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush_i),
        .flush_addr_i (flush_addr_i),
        .accept_i     (accept_i),
        .data_o       (data_o),
        .data_addr_o  (data_addr_o),
        .ready_o      (ready_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_mode;   // 0 random, 1 always, 2 never
    int gnt_mode;   // 0 random, 1 always, 2 never
    int lat_min;
    int lat_max;
    int n_grants;

    // scoreboard
    logic [64:0] exp_q[$];   // delivered words in order: {err, addr, data}
    logic [32:0] os_q[$];    // granted requests not yet answered: {stale, addr}
    logic [63:0] sl_q[$];    // slave side: {earliest response cycle, addr}
    logic [31:0] m_fetch;
    logic [31:0] m_hold_addr;
    logic        m_hold;
    logic        m_hold_stale;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic err_at(input logic [31:0] a);
        return (a[7:2] == 6'h01);
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        flush_i      = 1'b0;
        flush_addr_i = '0;
        accept_i     = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        bus_err_i    = 1'b0;
        exp_q.delete();
        os_q.delete();
        sl_q.delete();
        m_fetch      = RST_ADDR;
        m_hold       = 1'b0;
        m_hold_stale = 1'b0;
        m_hold_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   64'(bus_req_o),   64'(0));
        check("rst_ready", 64'(ready_o),     64'(0));
        check("rst_data",  64'(data_o),      64'(0));
        check("rst_daddr", 64'(data_addr_o), 64'(0));
        check("rst_err",   64'(err_o),       64'(0));
        check("rst_baddr", 64'(bus_addr_o),  64'(RST_ADDR));
        rst = 1'b0;
        #1;
        check("rst_req_rel", 64'(bus_req_o), 64'(0));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // driver: one bus cycle, compare against the model, then advance the model
    task automatic run_cycle(input logic fl, input logic [31:0] fa);
        logic        acc;
        logic        gnt;
        logic        rv;
        logic        stale;
        logic        e_ready;
        logic        e_pop;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] ra;
        logic [32:0] ent;
        int          used;

        acc = (acc_mode == 1) ? 1'b1 : (acc_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        rv  = 1'b0;
        ra  = '0;
        if (sl_q.size() != 0) begin
            if (int'(sl_q[0][63:32]) <= cyc) begin
                rv = 1'b1;
                ra = sl_q[0][31:0];
            end
        end
        accept_i     = acc;
        flush_i      = fl;
        flush_addr_i = fa;
        bus_rvalid_i = rv;
        bus_rdata_i  = rv ? mem_word(ra) : $urandom;
        bus_err_i    = rv ? err_at(ra) : 1'($urandom_range(0, 1));
        #1;
        gnt = (gnt_mode == 1) ? 1'b1 : (gnt_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        gnt = gnt & bus_req_o;
        bus_gnt_i = gnt;
        #1;

        e_ready = (exp_q.size() != 0);
        e_pop   = acc && e_ready;
        used    = os_q.size() + exp_q.size() - (e_pop ? 1 : 0);
        e_req   = m_hold || (used < DEPTH);
        e_addr  = m_hold ? m_hold_addr : m_fetch;

        check("ready", 64'(ready_o), 64'(e_ready));
        if (e_ready) begin
            check("data",  64'(data_o),      64'(exp_q[0][31:0]));
            check("daddr", 64'(data_addr_o), 64'(exp_q[0][63:32]));
            check("err",   64'(err_o),       64'(exp_q[0][64]));
        end
        check("req", 64'(bus_req_o), 64'(e_req));
        if (e_req && bus_req_o) check("baddr", 64'(bus_addr_o), 64'(e_addr));

        if (rv) begin
            void'(sl_q.pop_front());
            if (os_q.size() == 0) begin
                check("resp_unexpected", 64'(1), 64'(0));
            end else begin
                ent = os_q.pop_front();
                if (!ent[32] && !fl) exp_q.push_back({err_at(ent[31:0]), ent[31:0], mem_word(ent[31:0])});
            end
        end
        if (e_pop && !fl) void'(exp_q.pop_front());

        if (gnt) begin
            stale = m_hold ? (m_hold_stale | fl) : fl;
            os_q.push_back({stale, e_addr});
            sl_q.push_back({32'(cyc + int'($urandom_range(lat_max, lat_min))), bus_addr_o});
            n_grants++;
            if (!stale) m_fetch = m_fetch + 32'd4;
            m_hold       = 1'b0;
            m_hold_stale = 1'b0;
        end else if (bus_req_o) begin
            if (!m_hold) m_hold_addr = e_addr;
            m_hold_stale = (m_hold ? m_hold_stale : 1'b0) | fl;
            m_hold       = 1'b1;
        end else begin
            m_hold       = 1'b0;
            m_hold_stale = 1'b0;
        end

        if (fl) begin
            exp_q.delete();
            foreach (os_q[i]) os_q[i][32] = 1'b1;
            m_fetch = {fa[31:2], 2'b00};
        end

        @(posedge clk);
        #1;
        cyc++;
        flush_i = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        found;
        logic [31:0] ha;

        acc_mode = 1;
        gnt_mode = 1;
        lat_min  = 1;
        lat_max  = 1;
        n_grants = 0;
        do_reset();

        // zero-wait streaming from the top of the address space
        check("wrap_req0", 64'(bus_req_o), 64'(1));
        check("wrap_a0", 64'(bus_addr_o), 64'(32'hFFFF_FFFC));
        run_cycle(1'b0, '0);
        check("wrap_a1", 64'(bus_addr_o), 64'(32'h0000_0000));
        run_cycle(1'b0, '0);
        check("lat2_rdy", 64'(ready_o), 64'(1));
        check("lat2_addr", 64'(data_addr_o), 64'(32'hFFFF_FFFC));
        repeat (6) begin
            run_cycle(1'b0, '0);
            check("tput", 64'(ready_o), 64'(1));
        end

        // flush in a cycle carrying rvalid, ready and accept together
        run_cycle(1'b1, 32'h0000_0100);
        check("same_rdy", 64'(ready_o), 64'(0));

        // error flag on the word at 0x104 only
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ready_o && data_addr_o == 32'h104) found = 1'b1;
            else run_cycle(1'b0, '0);
        end
        check("err_seen", 64'(found), 64'(1));
        if (found) begin
            check("err_104", 64'(err_o), 64'(1));
            run_cycle(1'b0, '0);
            check("err_108", 64'({ready_o, data_addr_o, err_o}), 64'({1'b1, 32'h108, 1'b0}));
        end

        // back-pressure
        acc_mode = 2;
        n_grants = 0;
        repeat (10) run_cycle(1'b0, '0);
        check("bp_grants", 64'(n_grants <= DEPTH), 64'(1));
        check("bp_req", 64'(bus_req_o), 64'(0));
        check("bp_ready", 64'(ready_o), 64'(1));
        acc_mode = 1;
        repeat (8) run_cycle(1'b0, '0);

        // flush with two live requests outstanding
        lat_min = 3;
        lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (os_q.size() == 2) found = 1'b1;
            else run_cycle(1'b0, '0);
        end
        check("fl_two_out", 64'(found), 64'(1));
        run_cycle(1'b1, 32'h0000_2002);
        check("fl_rdy", 64'(ready_o), 64'(0));
        check("fl_addr", 64'(bus_addr_o), 64'(32'h0000_2000));
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (ready_o) found = 1'b1;
            else run_cycle(1'b0, '0);
        end
        check("fl_first_seen", 64'(found), 64'(1));
        check("fl_first", 64'(data_addr_o), 64'(32'h0000_2000));
        repeat (6) run_cycle(1'b0, '0);

        // flush while a request is held without grant
        lat_min  = 1;
        lat_max  = 1;
        gnt_mode = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_hold) found = 1'b1;
            else run_cycle(1'b0, '0);
        end
        check("hold_seen", 64'(found), 64'(1));
        ha = bus_addr_o;
        run_cycle(1'b0, '0);
        check("hold_a1", 64'(bus_addr_o), 64'(ha));
        run_cycle(1'b1, 32'h0000_2000);
        check("hold_a2", 64'(bus_addr_o), 64'(ha));
        check("hold_req", 64'(bus_req_o), 64'(1));
        run_cycle(1'b0, '0);
        check("hold_a3", 64'(bus_addr_o), 64'(ha));
        gnt_mode = 1;
        run_cycle(1'b0, '0);
        check("hold_next", 64'({bus_req_o, bus_addr_o}), 64'({1'b1, 32'h0000_2000}));
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (ready_o) found = 1'b1;
            else run_cycle(1'b0, '0);
        end
        check("hold_first_seen", 64'(found), 64'(1));
        check("hold_first", 64'(data_addr_o), 64'(32'h0000_2000));

        // randomized traffic with flushes and a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                acc_mode = $urandom_range(0, 2);
                gnt_mode = $urandom_range(0, 1);
                lat_min  = 1;
                lat_max  = $urandom_range(1, 4);
            end
            if (i == 1500) do_reset();
            if ($urandom_range(0, 29) == 0) run_cycle(1'b1, $urandom);
            else run_cycle(1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kmkz_ifetch_bus.md
# kmkz_ifetch_bus

Instruction-side bus master directly upstream of `kamikaze_fetch_fifo`. It owns the sequential word-fetch address, issues pipelined read requests on a req/gnt/rvalid instruction bus, and buffers returned words. Words are presented to the fetch FIFO as `data_o`/`ready_o`. On a branch it discards in-flight responses and restarts fetching at the new target, so the FIFO only ever sees words from the current fetch stream.

## Interface
- `RESET_ADDR`, default 32'h0000_0000: first fetch address after reset; bits [1:0] ignored.
- `BUF_DEPTH`, default 2: response buffer entries, which is also the max credits (outstanding + buffered). Legal values are 2 and 4.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: branch; discard stream and restart at `flush_addr_i` (fed from `branch_i`).
- `flush_addr_i` in 32: new fetch address; bits [1:0] forced to 0.
- `accept_i` in 1: consumer takes head word this cycle (FIFO not full).
- `data_o` out 32: head word (to FIFO `ir_i`).
- `data_addr_o` out 32: word address of `data_o`.
- `ready_o` out 1: `data_o` valid (to FIFO `memory_ready_i`).
- `err_o` out 1: head word returned with bus error; qualified by `ready_o`.
- `bus_req_o` out 1: read request.
- `bus_addr_o` out 32: request address, word aligned.
- `bus_gnt_i` in 1: request accepted this cycle.
- `bus_rvalid_i` in 1: response valid; responses arrive in order.
- `bus_rdata_i` in 32: response data.
- `bus_err_i` in 1: response error, qualified by `bus_rvalid_i`.

## Operation
- **State**
  - `fetch_addr`: 32-bit register.
  - `outstanding`: granted-but-unanswered count, 0..BUF_DEPTH.
  - `drop_cnt`: responses still to discard, 0..BUF_DEPTH.
  - Response buffer: `BUF_DEPTH` entries of {data, addr, err}.
  - `hold`: 1 while a request is raised but not yet granted.
  - `hold_stale`: 1 if that held request predates a flush.
- **Issue rule**: `bus_req_o` = `hold` | (`outstanding` + `buf_count` + `drop_cnt` < `BUF_DEPTH`). This credit rule guarantees every response has a buffer slot, so there is no back-pressure on rvalid.
- **Request hold**: once `bus_req_o` rises, it and `bus_addr_o` stay stable until `bus_gnt_i`, even across a flush.
- **Grant**: increments `outstanding` and sets `fetch_addr` += 4, wrapping mod 2^32. A grant of a `hold_stale` request increments `drop_cnt` instead of `outstanding`. `bus_addr_o` then presents the restarted address from the next cycle.
- **Response**
  - If `drop_cnt` > 0, the response is discarded and `drop_cnt` decrements.
  - Otherwise the response is pushed with the address of its request, and `outstanding` decrements.
- **Pop**: `accept_i` & `ready_o` removes the head entry. `accept_i` without `ready_o` is ignored.
- **Flush**, applied in the flush cycle:
  - Buffer cleared.
  - `drop_cnt` += `outstanding` − (1 if a non-dropped rvalid arrives this cycle); `outstanding` := 0.
  - `fetch_addr` := `flush_addr_i` & ~3.
  - A held ungranted request becomes `hold_stale`.
  - Flush overrides same-cycle push and pop.
- **Reset values**
  - `bus_req_o`=0, `bus_addr_o`=RESET_ADDR & ~3, `ready_o`=0, `err_o`=0, `data_o`=0, `data_addr_o`=0.
  - All counters = 0, `fetch_addr` = RESET_ADDR & ~3.
- **Reset mid-transaction**: the bus slave is reset by the same `rst_i`; no responses survive.

## Timing
- `bus_req_o` is asserted combinationally from registered state; the first request is in the first cycle after reset release.
- Grant in cycle N allows rvalid at N+1 or later.
- A word pushed in cycle M shows `ready_o`=1 in cycle M+1, with no rdata-to-output bypass.
- Minimum latency is 2 cycles from granted request to `ready_o`: same-cycle gnt, next-cycle rvalid.
- Steady state with 1-cycle memory and continuous `accept_i` gives 1 word/cycle at `BUF_DEPTH`=2.
- Flush in cycle F:
  - `ready_o`=0 in F+1.
  - First post-flush request at F+1 if no hold is pending.
  - First new word no earlier than F+3.
- Push and pop in the same cycle keep `buf_count` unchanged, including at full.

## Structure
- Shared package `kmkz_pkg`: `KMKZ_XLEN`=32, `KMKZ_WORD_BYTES`=4, and a response-entry typedef {data, addr, err}.
- One sub-module, `kmkz_ifetch_rbuf`: a parameterised synchronous FIFO of response entries with push/pop/clear, count, and empty/full flags. The credit, hold and drop logic stays in the top level.

## Test plan
- **Reset, zero-wait memory, `accept_i`=1, RESET_ADDR=0x100**: requests 0x100, 0x104, 0x108 on consecutive cycles. The first `ready_o` arrives 2 cycles after the first grant, with `data_addr_o`=0x100. Output is then 1 word/cycle.
- **Back-pressure, `accept_i`=0 for 10 cycles**: at most `BUF_DEPTH` grants occur and `bus_req_o` drops. Releasing `accept_i` drains words in address order with none lost or duplicated.
- **Flush to 0x2002 with 2 outstanding**: two late rvalids are discarded, and the next `bus_addr_o` is 0x2000. The first delivered `data_addr_o` is 0x2000, with no pre-flush word after F.
- **Flush while req is held with gnt low for 3 cycles**: the old address stays stable until gnt. Its response is dropped, then 0x2000 is requested.
- **`bus_err_i` on the word at 0x104**: that word has `err_o`=1 alongside `ready_o`, and neighbouring words have `err_o`=0.
- **Wrap and same-cycle events**: RESET_ADDR=0xFFFF_FFFC gives requests 0xFFFF_FFFC then 0x0. A flush in the same cycle as rvalid plus accept leaves `ready_o`=0 next cycle and `drop_cnt` correct.
